fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 81 ++++++++
 tb/tb_fetch_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the pipelined LEGv8 core.
// Holds the PC, applies decode-stage stalls and delay-slot branch redirects.
module fetch_stage #(
  parameter int                 ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [31:0]        BUBBLE   = 32'h910003FF
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              br_taken,
  input  logic              uncond_br,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_valid,
  output logic [31:0]       fetch_count
);

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] id_pc_reg, id_pc_next;
  logic [31:0]       id_instr_reg, id_instr_next;
  logic              id_valid_reg, id_valid_next;
  logic [31:0]       fetch_count_reg, fetch_count_next;

  logic [ADDR_W-1:0] br_offset;
  logic [ADDR_W-1:0] br_target;
  logic              redirect;

  // Word offsets are sign-extended and scaled to bytes in one concatenation.
  always_comb begin
    if (uncond_br) begin
      br_offset = {{(ADDR_W-28){id_instr_reg[25]}}, id_instr_reg[25:0], 2'b00};
    end else begin
      br_offset = {{(ADDR_W-21){id_instr_reg[23]}}, id_instr_reg[23:5], 2'b00};
    end
    br_target = id_pc_reg + br_offset;
  end

  // A bubble in IF/ID must never redirect, whatever decode reports.
  assign redirect = br_taken & id_valid_reg;

  always_comb begin
    pc_next          = pc_reg;
    id_pc_next       = id_pc_reg;
    id_instr_next    = id_instr_reg;
    id_valid_next    = id_valid_reg;
    fetch_count_next = fetch_count_reg;
    if (!stall) begin
      pc_next          = redirect ? br_target : pc_reg + {{(ADDR_W-3){1'b0}}, 3'd4};
      id_instr_next    = imem_data;
      id_pc_next       = pc_reg;
      id_valid_next    = 1'b1;
      fetch_count_next = fetch_count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg          <= RESET_PC;
      id_pc_reg       <= '0;
      id_instr_reg    <= BUBBLE;
      id_valid_reg    <= 1'b0;
      fetch_count_reg <= '0;
    end else begin
      pc_reg          <= pc_next;
      id_pc_reg       <= id_pc_next;
      id_instr_reg    <= id_instr_next;
      id_valid_reg    <= id_valid_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  assign imem_addr   = pc_reg;
  assign id_instr    = id_instr_reg;
  assign id_pc       = id_pc_reg;
  assign id_valid    = id_valid_reg;
  assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a cycle-level architectural model predicts the
// visible state after every edge; a monitor pops the predictions and compares.
module tb_fetch_stage;

  localparam logic [31:0] BUBBLE = 32'h910003FF;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, uncond_br;
  logic [63:0] imem_addr, id_pc;
  logic [31:0] imem_data, id_instr, fetch_count;
  logic        id_valid;

  fetch_stage #(.ADDR_W(64), .RESET_PC(64'h0), .BUBBLE(BUBBLE)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .br_taken(br_taken), .uncond_br(uncond_br),
    .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Instruction memory contents: directed overrides, else a simple address pattern.
  logic [31:0] ovr [logic [63:0]];
  bit          hash_mode = 1'b0;
  logic [31:0] seed = 32'h0;

  function automatic logic [31:0] imem_fn(logic [63:0] a);
    if (ovr.exists(a)) return ovr[a];
    if (hash_mode) return (a[31:0] * 32'h9E3779B1) ^ seed;
    return 32'hAAAA0000 + a[31:0];
  endfunction

  // Architectural model state
  logic [63:0] m_pc, m_idpc;
  logic [31:0] m_instr, m_cnt;
  bit          m_valid;

  function automatic logic [63:0] model_target(bit ub);
    logic signed [25:0] s26;
    logic signed [18:0] s19;
    longint off;
    s26 = m_instr[25:0];
    s19 = m_instr[23:5];
    off = ub ? longint'(s26) : longint'(s19);
    return m_idpc + 64'(off * 4);
  endfunction

  task automatic cycle(input bit rst, input bit stl, input bit br, input bit ub);
    exp_t e;
    logic [63:0] npc;
    @(negedge clk);
    reset = rst; stall = stl; br_taken = br; uncond_br = ub;
    imem_data = imem_fn(imem_addr);
    if (rst) begin
      m_pc = 64'h0; m_idpc = 64'h0; m_instr = BUBBLE; m_valid = 0; m_cnt = 0;
    end else if (!stl) begin
      npc     = (br && m_valid) ? model_target(ub) : m_pc + 64'd4;
      m_instr = imem_fn(m_pc);
      m_idpc  = m_pc;
      m_valid = 1;
      m_cnt   = m_cnt + 1;
      m_pc    = npc;
    end
    e.addr = m_pc; e.instr = m_instr; e.pc = m_idpc; e.valid = m_valid; e.cnt = m_cnt;
    expq.push_back(e);
  endtask

  task automatic run_until(input logic [63:0] want);
    int n = 0;
    while (!(m_valid && m_idpc == want) && n < 300) begin
      cycle(0, 0, 0, 0);
      n++;
    end
    checks++;
    if (!(m_valid && m_idpc == want)) begin
      errors++;
      $display("FAIL reach_pc: model id_pc=%h required %h within 300 cycles", m_idpc, want);
    end
  endtask

  // Monitor: one comparison line set per transaction
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      txn++;
      checks += 5;
      if (imem_addr !== e.addr) begin
        errors++; $display("FAIL imem_addr txn %0d: got %h expected %h", txn, imem_addr, e.addr);
      end
      if (id_instr !== e.instr) begin
        errors++; $display("FAIL id_instr txn %0d: got %h expected %h", txn, id_instr, e.instr);
      end
      if (id_pc !== e.pc) begin
        errors++; $display("FAIL id_pc txn %0d: got %h expected %h", txn, id_pc, e.pc);
      end
      if (id_valid !== e.valid) begin
        errors++; $display("FAIL id_valid txn %0d: got %b expected %b", txn, id_valid, e.valid);
      end
      if (fetch_count !== e.cnt) begin
        errors++; $display("FAIL fetch_count txn %0d: got %0d expected %0d", txn, fetch_count, e.cnt);
      end
      $display("txn %0d: addr=%h id_instr=%h id_pc=%h valid=%b count=%0d",
               txn, imem_addr, id_instr, id_pc, id_valid, fetch_count);
    end
  end

  initial begin
    reset = 1; stall = 0; br_taken = 0; uncond_br = 0; imem_data = 32'h0;
    m_pc = 0; m_idpc = 0; m_instr = BUBBLE; m_valid = 0; m_cnt = 0;

    // Reset, then three free-running fetches
    cycle(1, 1, 1, 0);
    cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);

    // Unconditional B +16 words at 0x20
    ovr[64'h20] = 32'h14000010;
    run_until(64'h20);
    cycle(0, 0, 1, 1);
    repeat (3) cycle(0, 0, 0, 0);

    // Backward CBZ (imm19 = -2) at 0x100
    ovr[64'h100] = 32'hB4FFFFC0;
    run_until(64'h100);
    cycle(0, 0, 1, 0);
    repeat (3) cycle(0, 0, 0, 0);

    // Stall for two cycles with br_taken held, then redirect when released
    cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 1);
    cycle(0, 0, 1, 1);
    // Back-to-back taken branches: the delay slot also branches
    cycle(0, 0, 1, 0);
    repeat (2) cycle(0, 0, 0, 0);

    // Wrap: B -1 at address 0 sends the PC to the top of the address space
    ovr[64'h0] = 32'h17FFFFFF;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 1);
    repeat (3) cycle(0, 0, 0, 0);

    // Reset while stalled with a branch pending
    cycle(0, 1, 1, 0);
    cycle(1, 1, 1, 0);
    cycle(0, 0, 1, 0);   // bubble in ID must not branch
    repeat (2) cycle(0, 0, 0, 0);

    // Randomized traffic
    ovr.delete();
    hash_mode = 1'b1;
    seed = $urandom;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 25),
            ($urandom_range(0, 99) < 20), $urandom_range(0, 1) == 1);
    end

    @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, required 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
